// File: rtl/trng_cm_tx.sv
// Purpose: TRNG transmit side of the 8-bit CM bus. Samples the ring-oscillator bank, XOR-compresses
//          it to one raw bit per sample, packs bytes into a FWFT FIFO, and hands bytes to the MCU on
//          a request/strobe handshake.
// Ports:   CLK/RST (async active-high), RO_IN (async RO bank), MCU_REQ (async level request),
//          CM_OUT/CM_OE/CM_STB (bus data, output-enable, data-valid strobe), FIFO_LEVEL, OVF (sticky drop).
// Option:  define TRNG_VON_NEUMANN_EN to debias raw samples in pairs (01->0, 10->1, 00/11 discarded).
module trng_cm_tx #(
    parameter int N_RO       = 20,
    parameter int SAMPLE_DIV = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int SETUP_CYC  = 4,
    parameter int STB_CYC    = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [N_RO-1:0]               RO_IN,
    input  logic                          MCU_REQ,
    output logic [7:0]                    CM_OUT,
    output logic                          CM_OE,
    output logic                          CM_STB,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          OVF
);
    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(SETUP_CYC + STB_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_WAIT_REL} state_t;

    // Synchronisers
    logic [N_RO-1:0] ro_s1_q, ro_s2_q;
    logic            req_s1_q, req_s2_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ro_s1_q  <= '0;
            ro_s2_q  <= '0;
            req_s1_q <= 1'b0;
            req_s2_q <= 1'b0;
        end else begin
            ro_s1_q  <= RO_IN;
            ro_s2_q  <= ro_s1_q;
            req_s1_q <= MCU_REQ;
            req_s2_q <= req_s1_q;
        end
    end

    // Sampling and byte assembly
    logic [CW-1:0] cnt_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    acc_q;
    logic          push_q;
    logic          samp_wrap, raw;
    logic          bit_vld, bit_val;

    assign samp_wrap = (cnt_q == CW'(SAMPLE_DIV - 1));
    assign raw       = ^ro_s2_q;

`ifdef TRNG_VON_NEUMANN_EN
    // half_q marks that the first sample of a pair is held in vn_first_q.
    logic half_q, vn_first_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            half_q     <= 1'b0;
            vn_first_q <= 1'b0;
        end else if (samp_wrap) begin
            half_q <= ~half_q;
            if (!half_q) vn_first_q <= raw;
        end
    end

    // Unequal pair yields its first sample (01 -> 0, 10 -> 1).
    always_comb begin
        bit_vld = samp_wrap && half_q && (vn_first_q != raw);
        bit_val = vn_first_q;
    end
`else
    always_comb begin
        bit_vld = samp_wrap;
        bit_val = raw;
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q    <= '0;
            bitcnt_q <= '0;
            acc_q    <= '0;
            push_q   <= 1'b0;
        end else begin
            push_q <= 1'b0;
            cnt_q  <= samp_wrap ? '0 : cnt_q + CW'(1);
            if (bit_vld) begin
                acc_q    <= {acc_q[6:0], bit_val};
                bitcnt_q <= bitcnt_q + 3'd1;
                // Byte is complete in acc_q on the following cycle, when push_q is seen.
                if (bitcnt_q == 3'd7) push_q <= 1'b1;
            end
        end
    end

    // Byte FIFO (first-word fall-through)
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          ovf_q;
    logic          pop, push_ok, full;
    state_t        state_q;
    logic [TW-1:0] tmr_q;

    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign pop     = (state_q == ST_STROBE) && (tmr_q == TW'(STB_CYC - 1));
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign push_ok = push_q && (!full || pop);

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr_q] <= acc_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_ok && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !push_ok) level_q <= level_q - LW'(1);
            if (push_q && !push_ok)   ovf_q   <= 1'b1;
        end
    end

    // Transmit FSM with registered bus outputs
    logic [7:0] cm_out_q;
    logic       oe_q, stb_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            cm_out_q <= '0;
            oe_q     <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s2_q && (level_q != '0)) begin
                        cm_out_q <= mem[rd_ptr_q];
                        oe_q     <= 1'b1;
                        tmr_q    <= '0;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_q == TW'(SETUP_CYC - 1)) begin
                        stb_q   <= 1'b1;
                        tmr_q   <= '0;
                        state_q <= ST_STROBE;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                ST_STROBE: begin
                    if (tmr_q == TW'(STB_CYC - 1)) begin
                        stb_q   <= 1'b0;
                        tmr_q   <= '0;
                        state_q <= ST_WAIT_REL;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                ST_WAIT_REL: begin
                    // Only the release of the request ends the transfer; one byte per request.
                    if (!req_s2_q) begin
                        oe_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign CM_OUT     = cm_out_q;
    assign CM_OE      = oe_q;
    assign CM_STB     = stb_q;
    assign FIFO_LEVEL = level_q;
    assign OVF        = ovf_q;

endmodule
